// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Initiator side of the data-memory port. Takes RISC-V load/store requests
// from the CPU datapath over a ready/valid handshake and turns them into
// word-aligned memory accesses. Loads are lane-selected and sign/zero
// extended. Sub-word stores read the target word through the memory's
// combinational read port, merge the new lane(s), and write the whole word
// back on a clock edge. Every accepted request ends with a one-cycle
// respValid pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqValid/reqReady          request handshake (accept when both high)
//   reqStore, reqFunct3        operation: store/load and RISC-V width code
//   reqAddr, reqData, reqPc    byte address, right-aligned store data, PC
//   respValid, respData        completion pulse and extended load result
//   respError                  request rejected (only with the trap macro)
//   memAddr                    word address of the access (0 when idle)
//   memWriteEnable             write strobe, data in memWriteData
//   memReadData                combinational read data for memAddr
//   memPc                      latched PC for the memory's write log
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses and illegal funct3 codes are
//               rejected with respError and never touch memory
//   undefined - respError is 0, offending low address bits are ignored and
//               illegal funct3 codes behave as word accesses

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module load_store_unit (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqStore,
    input  logic [2:0]            reqFunct3,
    input  logic [`ADDR_SIZE-1:0] reqAddr,
    input  logic [`WORD_LEN-1:0]  reqData,
    input  logic [`ADDR_SIZE-1:0] reqPc,
    output logic                  respValid,
    output logic [`WORD_LEN-1:0]  respData,
    output logic                  respError,
    output logic [`ADDR_SIZE-1:0] memAddr,
    output logic                  memWriteEnable,
    output logic [`WORD_LEN-1:0]  memWriteData,
    input  logic [`WORD_LEN-1:0]  memReadData,
    output logic [`ADDR_SIZE-1:0] memPc
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t                  state;
    logic [`ADDR_SIZE-1:0]   addr_reg;
    logic [`WORD_LEN-1:0]    data_reg;
    logic [`ADDR_SIZE-1:0]   pc_reg;
    logic [2:0]              funct3_reg;
    logic                    store_reg;
    logic                    error_reg;
    logic [`WORD_LEN-1:0]    merge_reg;
    logic [`WORD_LEN-1:0]    resp_data_reg;

    size_t                   req_size;
    size_t                   size_reg;
    logic                    req_error;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [`WORD_LEN-1:0]    load_result;
    logic [`WORD_LEN-1:0]    merged;

    // Any code that is not a legal B/H/BU/HU falls back to a word access;
    // the unsigned variants only exist for loads.
    function automatic size_t decode_size(input logic [2:0] f3, input logic st);
        size_t sz;
        sz = SZ_WORD;
        if (f3 == 3'b000 || (!st && f3 == 3'b100))
            sz = SZ_BYTE;
        else if (f3 == 3'b001 || (!st && f3 == 3'b101))
            sz = SZ_HALF;
        return sz;
    endfunction

    assign req_size = decode_size(reqFunct3, reqStore);
    assign size_reg = decode_size(funct3_reg, store_reg);

    always_comb begin
        req_error = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (reqFunct3 == 3'b011 || reqFunct3[2:1] == 2'b11 || (reqStore && reqFunct3[2]))
            req_error = 1'b1;
        else if (req_size == SZ_HALF && reqAddr[0])
            req_error = 1'b1;
        else if (req_size == SZ_WORD && reqAddr[1:0] != 2'b00)
            req_error = 1'b1;
`endif
    end

    // Lane extraction for loads; addr[0] is ignored for halves so that the
    // non-trapping build simply rounds misaligned halves down.
    always_comb begin
        byte_val = memReadData[7:0];
        case (addr_reg[1:0])
            2'd1:    byte_val = memReadData[15:8];
            2'd2:    byte_val = memReadData[23:16];
            2'd3:    byte_val = memReadData[31:24];
            default: byte_val = memReadData[7:0];
        endcase
        half_val = addr_reg[1] ? memReadData[31:16] : memReadData[15:0];
        load_result = memReadData;
        if (size_reg == SZ_BYTE)
            load_result = funct3_reg[2] ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
        else if (size_reg == SZ_HALF)
            load_result = funct3_reg[2] ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
    end

    // Read-modify-write merge: only the addressed lane(s) change, all other
    // bits come straight from the word read back from memory.
    always_comb begin
        merged = memReadData;
        if (size_reg == SZ_BYTE) begin
            case (addr_reg[1:0])
                2'd1:    merged[15:8]  = data_reg[7:0];
                2'd2:    merged[23:16] = data_reg[7:0];
                2'd3:    merged[31:24] = data_reg[7:0];
                default: merged[7:0]   = data_reg[7:0];
            endcase
        end else if (addr_reg[1]) begin
            merged[31:16] = data_reg[15:0];
        end else begin
            merged[15:0] = data_reg[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_reg      <= '0;
            data_reg      <= '0;
            pc_reg        <= '0;
            funct3_reg    <= '0;
            store_reg     <= 1'b0;
            error_reg     <= 1'b0;
            merge_reg     <= '0;
            resp_data_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        addr_reg      <= reqAddr;
                        data_reg      <= reqData;
                        pc_reg        <= reqPc;
                        funct3_reg    <= reqFunct3;
                        store_reg     <= reqStore;
                        error_reg     <= req_error;
                        resp_data_reg <= '0;
                        if (req_error)
                            state <= RESP;
                        else if (!reqStore)
                            state <= LOAD;
                        else if (req_size == SZ_WORD)
                            state <= STORE_WR;
                        else
                            state <= STORE_RD;
                    end
                end
                LOAD: begin
                    resp_data_reg <= load_result;
                    state         <= RESP;
                end
                STORE_RD: begin
                    merge_reg <= merged;
                    state     <= STORE_WR;
                end
                STORE_WR: state <= RESP;
                RESP:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign reqReady       = (state == IDLE);
    assign respValid      = (state == RESP);
    assign respData       = resp_data_reg;
    assign respError      = (state == RESP) & error_reg;
    assign memAddr        = (state == IDLE) ? '0 : {addr_reg[`ADDR_SIZE-1:2], 2'b00};
    assign memPc          = pc_reg;
    // Reset gates the strobe directly so a reset landing in STORE_WR can
    // never commit a partial read-modify-write.
    assign memWriteEnable = (state == STORE_WR) & ~error_reg & ~reset;
    assign memWriteData   = (state != STORE_WR) ? '0 :
                            (size_reg == SZ_WORD) ? data_reg : merge_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. A small word-addressed memory
// model serves the combinational read port and commits writes on posedge.
// Inputs change on the falling edge and outputs are sampled there too, so
// "cycle N" below means the negedge after the N-th posedge since accept.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqStore = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqData = 32'd0;
    logic [31:0] reqPc = 32'd0;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] memAddr;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic [31:0] memPc;

    logic [31:0] mem [0:63];
    logic        preload_en = 1'b0;
    logic [5:0]  preload_idx = 6'd0;
    logic [31:0] preload_val = 32'd0;
    int          write_count = 0;
    int          resp_count = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore),
        .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqData(reqData), .reqPc(reqPc),
        .respValid(respValid), .respData(respData), .respError(respError),
        .memAddr(memAddr), .memWriteEnable(memWriteEnable), .memWriteData(memWriteData),
        .memReadData(memReadData), .memPc(memPc)
    );

    always #5 clk = ~clk;

    // Memory model: preloads from the bench take priority over DUT writes,
    // and every DUT write and response pulse is counted.
    assign memReadData = mem[memAddr[7:2]];

    always @(posedge clk) begin
        if (preload_en)
            mem[preload_idx] <= preload_val;
        else if (memWriteEnable) begin
            mem[memAddr[7:2]] <= memWriteData;
            write_count <= write_count + 1;
        end
        if (respValid)
            resp_count <= resp_count + 1;
    end

    // Puts a word into the memory model while the DUT is idle.
    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        preload_en  = 1'b1;
        preload_idx = addr[7:2];
        preload_val = val;
        @(negedge clk);
        preload_en  = 1'b0;
    endtask

    // Presents one request for a single accept edge; returns in cycle 1.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] pc);
        reqStore  = st;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqData   = data;
        reqPc     = pc;
        reqValid  = 1'b1;
        @(negedge clk);
        reqValid  = 1'b0;
    endtask

    // Reset state of every interface output, during and after reset.
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (memWriteEnable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_we_during: got %b expected 0", memWriteEnable);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (reqReady !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 1", reqReady);
        end
        tests_run++;
        if (respValid !== 1'b0 || respError !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got valid=%b err=%b expected 0/0", respValid, respError);
        end
        tests_run++;
        if (memWriteEnable !== 1'b0 || memAddr !== 32'd0 || memPc !== 32'd0 ||
            memWriteData !== 32'd0 || respData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem: got we=%b addr=%h pc=%h wd=%h rd=%h expected all 0",
                     memWriteEnable, memAddr, memPc, memWriteData, respData);
        end
    endtask

    // Loads from a known word: lane selection plus sign/zero extension.
    task automatic test_loads();
        logic [2:0]  f3 [7]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101};
        logic [31:0] ad [7]   = '{32'h40, 32'h41, 32'h42, 32'h42, 32'h40, 32'h43, 32'h40};
        logic [31:0] ex [7]   = '{32'hFFFFFFAA, 32'h000000F0, 32'hFFFF8077, 32'h00008077,
                                  32'h8077F0AA, 32'hFFFFFF80, 32'h0000F0AA};
        int          wc;
        preload(32'h40, 32'h8077F0AA);
        wc = write_count;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, f3[i], ad[i], 32'hFFFFFFFF, 32'h200 + i);
            tests_run++;
            if (respValid !== 1'b0 || reqReady !== 1'b0 || memAddr !== 32'h40) begin
                tests_failed++;
                $display("[TB] FAIL load%0d_cycle1: got valid=%b ready=%b addr=%h expected 0/0/00000040",
                         i, respValid, reqReady, memAddr);
            end
            @(negedge clk);
            tests_run++;
            if (respValid !== 1'b1 || respData !== ex[i] || respError !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL load%0d_data: got valid=%b data=%h err=%b expected 1/%h/0",
                         i, respValid, respData, respError, ex[i]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (write_count !== wc || reqReady !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_no_write: got writes=%0d ready=%b expected %0d/1",
                     write_count - wc, reqReady, 0);
        end
    endtask

    // Byte/half stores: one merged write at cycle 2, response at cycle 3.
    task automatic test_subword_store();
        logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b000};
        logic [31:0] ad [3] = '{32'h41, 32'h42, 32'h43};
        logic [31:0] dt [3] = '{32'h123456AB, 32'hCAFEBEEF, 32'h00000055};
        logic [31:0] ex [3] = '{32'h1122AB44, 32'hBEEF3344, 32'h55223344};
        int          wc;
        for (int i = 0; i < 3; i++) begin
            preload(32'h40, 32'h11223344);
            wc = write_count;
            applyStimulus(1'b1, f3[i], ad[i], dt[i], 32'h300 + i);
            tests_run++;
            if (memWriteEnable !== 1'b0 || respValid !== 1'b0 || memAddr !== 32'h40) begin
                tests_failed++;
                $display("[TB] FAIL sub%0d_cycle1: got we=%b valid=%b addr=%h expected 0/0/00000040",
                         i, memWriteEnable, respValid, memAddr);
            end
            @(negedge clk);
            tests_run++;
            if (memWriteEnable !== 1'b1 || memWriteData !== ex[i] || respValid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL sub%0d_write: got we=%b wd=%h valid=%b expected 1/%h/0",
                         i, memWriteEnable, memWriteData, respValid, ex[i]);
            end
            @(negedge clk);
            tests_run++;
            if (respValid !== 1'b1 || respData !== 32'd0 || mem[16] !== ex[i] ||
                write_count - wc !== 1) begin
                tests_failed++;
                $display("[TB] FAIL sub%0d_resp: got valid=%b data=%h mem=%h writes=%0d expected 1/0/%h/1",
                         i, respValid, respData, mem[16], write_count - wc, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    // Word store with reqValid held high across the whole transaction.
    task automatic test_back_to_back();
        int wc;
        int rc;
        preload(32'h80, 32'h00000000);
        wc = write_count;
        rc = resp_count;
        reqStore  = 1'b1;
        reqFunct3 = 3'b010;
        reqAddr   = 32'h80;
        reqData   = 32'hDEADBEEF;
        reqPc     = 32'h10000124;
        reqValid  = 1'b1;
        @(negedge clk);
        tests_run++;
        if (memWriteEnable !== 1'b1 || memWriteData !== 32'hDEADBEEF || memAddr !== 32'h80 ||
            memPc !== 32'h10000124 || reqReady !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sw_write: got we=%b wd=%h addr=%h pc=%h ready=%b expected 1/deadbeef/00000080/10000124/0",
                     memWriteEnable, memWriteData, memAddr, memPc, reqReady);
        end
        @(negedge clk);
        tests_run++;
        if (respValid !== 1'b1 || reqReady !== 1'b0 || memPc !== 32'h10000124) begin
            tests_failed++;
            $display("[TB] FAIL sw_resp: got valid=%b ready=%b pc=%h expected 1/0/10000124",
                     respValid, reqReady, memPc);
        end
        reqValid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (write_count - wc !== 1 || resp_count - rc !== 1 || reqReady !== 1'b1 ||
            mem[32] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL sw_once: got writes=%0d resps=%0d ready=%b mem=%h expected 1/1/1/deadbeef",
                     write_count - wc, resp_count - rc, reqReady, mem[32]);
        end
    endtask

    // Misaligned and illegal accesses: trapped with the macro, rounded without.
    task automatic test_misaligned();
        int wc;
        preload(32'h40, 32'h8077F0AA);
        wc = write_count;
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 3'b010, 32'h42, 32'd0, 32'h400);
        tests_run++;
        if (respValid !== 1'b1 || respError !== 1'b1 || memWriteEnable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lw_misalign: got valid=%b err=%b we=%b expected 1/1/0",
                     respValid, respError, memWriteEnable);
        end
        @(negedge clk);
        applyStimulus(1'b1, 3'b001, 32'h41, 32'h0000BEEF, 32'h404);
        tests_run++;
        if (respValid !== 1'b1 || respError !== 1'b1 || memWriteEnable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sh_misalign: got valid=%b err=%b we=%b expected 1/1/0",
                     respValid, respError, memWriteEnable);
        end
        @(negedge clk);
        applyStimulus(1'b1, 3'b100, 32'h40, 32'h000000FF, 32'h408);
        tests_run++;
        if (respValid !== 1'b1 || respError !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL store_illegal_f3: got valid=%b err=%b expected 1/1",
                     respValid, respError);
        end
        @(negedge clk);
        tests_run++;
        if (write_count !== wc || mem[16] !== 32'h8077F0AA || respError !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL trap_no_write: got writes=%0d mem=%h err=%b expected 0/8077f0aa/0",
                     write_count - wc, mem[16], respError);
        end
`else
        applyStimulus(1'b0, 3'b001, 32'h43, 32'd0, 32'h400);
        @(negedge clk);
        tests_run++;
        if (respValid !== 1'b1 || respData !== 32'hFFFF8077 || respError !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lh_round: got valid=%b data=%h err=%b expected 1/ffff8077/0",
                     respValid, respData, respError);
        end
        @(negedge clk);
        applyStimulus(1'b1, 3'b010, 32'h43, 32'h0BADF00D, 32'h404);
        tests_run++;
        if (memWriteEnable !== 1'b1 || memAddr !== 32'h40 || memWriteData !== 32'h0BADF00D) begin
            tests_failed++;
            $display("[TB] FAIL sw_round_write: got we=%b addr=%h wd=%h expected 1/00000040/0badf00d",
                     memWriteEnable, memAddr, memWriteData);
        end
        @(negedge clk);
        tests_run++;
        if (respValid !== 1'b1 || respError !== 1'b0 || mem[16] !== 32'h0BADF00D ||
            write_count - wc !== 1) begin
            tests_failed++;
            $display("[TB] FAIL sw_round_resp: got valid=%b err=%b mem=%h writes=%0d expected 1/0/0badf00d/1",
                     respValid, respError, mem[16], write_count - wc);
        end
        @(negedge clk);
`endif
    endtask

    // Reset landing in STORE_WR of a byte store must suppress the write.
    task automatic test_reset_mid_store();
        int wc;
        int rc;
        preload(32'h40, 32'h11223344);
        wc = write_count;
        rc = resp_count;
        applyStimulus(1'b1, 3'b000, 32'h40, 32'h00000099, 32'h500);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (memWriteEnable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_wr_strobe: got we=%b expected 0", memWriteEnable);
        end
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_wr_idle: got ready=%b valid=%b expected 1/0", reqReady, respValid);
        end
        @(negedge clk);
        tests_run++;
        if (mem[16] !== 32'h11223344 || write_count !== wc || resp_count !== rc) begin
            tests_failed++;
            $display("[TB] FAIL rst_wr_mem: got mem=%h writes=%0d resps=%0d expected 11223344/0/0",
                     mem[16], write_count - wc, resp_count - rc);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_subword_store();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
